datapath_filtro: RTL and testbench



---
 rtl/filtro_pkg.sv | 22 ++
 rtl/mult_punto_fijo.sv | 37 +++
 rtl/datapath_filtro.sv | 132 +++++++++++++
 tb/tb_datapath_filtro.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared encodings and default widths for the filter datapath and its sequencer.
package filtro_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 8;
  localparam int GUARD_DEF = 4;

  typedef enum logic [1:0] {
    FUN_CERO = 2'b00,
    FUN_FK   = 2'b01,
    FUN_XK   = 2'b10,
    FUN_XK1  = 2'b11
  } sel_fun_t;

  typedef enum logic [1:0] {
    ACUM_CLR   = 2'b00,
    ACUM_SUMA  = 2'b01,
    ACUM_CARGA = 2'b10,
    ACUM_HOLD  = 2'b11
  } sel_acum_t;

endpackage

// File: rtl/mult_punto_fijo.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// saturated to the accumulator width. Purely combinational.
module mult_punto_fijo
  import filtro_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic signed [WIDTH-1:0]       i_coef,
  input  logic signed [WIDTH-1:0]       i_oper,
  output logic signed [WIDTH+GUARD-1:0] o_prod
);

  localparam int ACC = WIDTH + GUARD;
  localparam logic signed [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
  localparam logic signed [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_full;
  logic signed [2*WIDTH-1:0] w_shift;
  logic                      w_pos_ovf;
  logic                      w_neg_ovf;

  assign w_full  = i_coef * i_oper;
  assign w_shift = w_full >>> FRAC;

  // Result fits only if every bit above the ACC sign bit copies the sign.
  assign w_pos_ovf = !w_shift[2*WIDTH-1] &&  (|w_shift[2*WIDTH-2:ACC-1]);
  assign w_neg_ovf =  w_shift[2*WIDTH-1] && !(&w_shift[2*WIDTH-2:ACC-1]);

  always_comb begin
    o_prod = w_shift[ACC-1:0];
    if (w_pos_ovf) o_prod = ACC_MAX;
    else if (w_neg_ovf) o_prod = ACC_MIN;
  end

endmodule

// File: rtl/datapath_filtro.sv
// Filter arithmetic datapath: coefficient x operand, accumulate/load/clear,
// sample delay line, f_k register and one saturated output capture per sequence.
module datapath_filtro
  import filtro_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter logic signed [WIDTH-1:0] C0 = 256,
  parameter logic signed [WIDTH-1:0] C1 = 128,
  parameter logic signed [WIDTH-1:0] C2 = 64,
  parameter logic signed [WIDTH-1:0] C3 = -128,
  parameter logic signed [WIDTH-1:0] C4 = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] muestra_in,
  input  logic                    muestra_en,
  input  logic [2:0]              sel_const,
  input  logic [1:0]              sel_fun,
  input  logic [1:0]              sel_acum,
  input  logic                    Senal,
  input  logic                    Band_Listo,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    y_valid,
  output logic                    y_ovf
);

  localparam int ACC = WIDTH + GUARD;
  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] r_x_cur;
  logic signed [WIDTH-1:0] r_x_prev;
  logic signed [WIDTH-1:0] r_fk;
  logic signed [ACC-1:0]   r_acc;
  logic signed [WIDTH-1:0] r_y_out;
  logic                    r_y_valid;
  logic                    r_y_ovf;
  logic                    r_listo_d;

  logic signed [WIDTH-1:0] w_coef;
  logic signed [WIDTH-1:0] w_oper;
  logic signed [ACC-1:0]   w_p;
  logic signed [ACC:0]     w_sum;
  logic                    w_y_pos;
  logic                    w_y_neg;
  logic signed [WIDTH-1:0] w_y_sat;
  logic                    w_fk_pos;
  logic                    w_fk_neg;
  logic signed [WIDTH-1:0] w_fk_sat;

  always_comb begin
    case (sel_const)
      3'd1:    w_coef = C1;
      3'd2:    w_coef = C2;
      3'd3:    w_coef = C3;
      3'd4:    w_coef = C4;
      default: w_coef = C0;
    endcase
  end

  always_comb begin
    case (sel_fun_t'(sel_fun))
      FUN_FK:  w_oper = r_fk;
      FUN_XK:  w_oper = r_x_cur;
      FUN_XK1: w_oper = r_x_prev;
      default: w_oper = '0;
    endcase
  end

  mult_punto_fijo #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .GUARD (GUARD)
  ) u_mult (
    .i_coef (w_coef),
    .i_oper (w_oper),
    .o_prod (w_p)
  );

  // One extra bit so the captured sum saturates instead of wrapping like acc.
  assign w_sum   = {r_acc[ACC-1], r_acc} + {w_p[ACC-1], w_p};
  assign w_y_pos = !w_sum[ACC] &&  (|w_sum[ACC-1:WIDTH-1]);
  assign w_y_neg =  w_sum[ACC] && !(&w_sum[ACC-1:WIDTH-1]);
  assign w_y_sat = w_y_pos ? W_MAX : (w_y_neg ? W_MIN : w_sum[WIDTH-1:0]);

  // fk feeds a WIDTH-bit multiplier operand, so acc is saturated on the way in.
  assign w_fk_pos = !r_acc[ACC-1] &&  (|r_acc[ACC-2:WIDTH-1]);
  assign w_fk_neg =  r_acc[ACC-1] && !(&r_acc[ACC-2:WIDTH-1]);
  assign w_fk_sat = w_fk_pos ? W_MAX : (w_fk_neg ? W_MIN : r_acc[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x_cur   <= '0;
      r_x_prev  <= '0;
      r_fk      <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_y_ovf   <= 1'b0;
      r_listo_d <= 1'b0;
    end else begin
      if (muestra_en) r_x_cur <= muestra_in;
      if (Senal) r_x_prev <= r_x_cur;

      case (sel_acum_t'(sel_acum))
        ACUM_CLR:  r_acc <= '0;
        ACUM_SUMA: r_acc <= r_acc + w_p;
        ACUM_CARGA: begin
          r_fk  <= w_fk_sat;
          r_acc <= w_p;
        end
        default:   r_acc <= r_acc;
      endcase

      r_listo_d <= Band_Listo;
      r_y_valid <= 1'b0;
      r_y_ovf   <= 1'b0;
      if (Band_Listo && !r_listo_d) begin
        r_y_out   <= w_y_sat;
        r_y_valid <= 1'b1;
        r_y_ovf   <= w_y_pos | w_y_neg;
      end
    end
  end

  assign y_out   = r_y_out;
  assign y_valid = r_y_valid;
  assign y_ovf   = r_y_ovf;

endmodule

// File: tb/tb_datapath_filtro.sv
// Scoreboard bench for datapath_filtro: a cycle model predicts each cycle's outputs.
module tb_datapath_filtro;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] muestra_in = '0;
  logic               muestra_en = 1'b0;
  logic [2:0]         sel_const = '0;
  logic [1:0]         sel_fun = '0;
  logic [1:0]         sel_acum = 2'b11;
  logic               Senal = 1'b0;
  logic               Band_Listo = 1'b0;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               y_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int valid;
    int y;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  int               m_x_cur, m_x_prev, m_fk, m_y, m_listo_d;
  logic signed [19:0] m_acc;

  datapath_filtro dut (
    .clk        (clk),
    .reset      (reset),
    .muestra_in (muestra_in),
    .muestra_en (muestra_en),
    .sel_const  (sel_const),
    .sel_fun    (sel_fun),
    .sel_acum   (sel_acum),
    .Senal      (Senal),
    .Band_Listo (Band_Listo),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .y_ovf      (y_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Drive one cycle, advance the model, then compare the DUT just after the edge.
  task automatic do_cycle(input int c, input int f, input int a, input int s,
                          input int l, input int men, input int min, input int rst);
    longint coef, op, prod, p, sum, nacc;
    logic signed [19:0] acc_n;
    exp_t e, got;
    sel_const  = 3'(c);
    sel_fun    = 2'(f);
    sel_acum   = 2'(a);
    Senal      = 1'(s);
    Band_Listo = 1'(l);
    muestra_en = 1'(men);
    muestra_in = 16'(min);
    reset      = 1'(rst);

    case (c)
      1: coef = 128;
      2: coef = 64;
      3: coef = -128;
      4: coef = 32;
      default: coef = 256;
    endcase
    case (f)
      1: op = m_fk;
      2: op = m_x_cur;
      3: op = m_x_prev;
      default: op = 0;
    endcase
    prod = coef * op;
    p    = sat(prod >>> 8, 20);
    sum  = longint'(m_acc) + p;
    e.valid = 0;
    e.ovf   = 0;

    if (rst == 0) begin
      m_x_cur = 0; m_x_prev = 0; m_fk = 0; m_acc = '0; m_y = 0; m_listo_d = 0;
    end else begin
      if (l != 0 && m_listo_d == 0) begin
        m_y     = int'(sat(sum, 16));
        e.valid = 1;
        e.ovf   = (sat(sum, 16) != sum) ? 1 : 0;
      end
      m_listo_d = l;
      if (s != 0) m_x_prev = m_x_cur;
      if (men != 0) m_x_cur = int'(sat(longint'(min), 16));
      nacc  = (a == 1) ? sum : p;
      acc_n = nacc[19:0];
      if (a == 0) m_acc = '0;
      else if (a == 1) m_acc = acc_n;
      else if (a == 2) begin
        m_fk  = int'(sat(longint'(m_acc), 16));
        m_acc = acc_n;
      end
    end
    e.y = m_y;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_value("y_valid", int'(y_valid), got.valid);
    check_value("y_ovf", int'(y_ovf), got.ovf);
    check_value("y_out", int'(y_out), got.y);
    if (y_valid) $display("out y_out=%0d y_ovf=%0d", y_out, y_ovf);
  endtask

  task automatic idle();
    do_cycle(0, 0, 3, 0, 0, 0, 0, 1);
  endtask

  task automatic nominal(input int rst_in_listo);
    do_cycle(0, 0, 3, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 3, 0, 0, 1, 256, 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    do_cycle(0, 2, 1, 0, 0, 0, 0, 1);
    do_cycle(1, 3, 1, 1, 0, 0, 0, 1);
    do_cycle(2, 1, 2, 0, 0, 0, 0, 1);
    do_cycle(3, 2, 1, 0, 0, 0, 0, 1);
    do_cycle(4, 3, 1, 0, 1, 0, 0, (rst_in_listo != 0) ? 0 : 1);
  endtask

  initial begin
    m_x_cur = 0; m_x_prev = 0; m_fk = 0; m_acc = '0; m_y = 0; m_listo_d = 0;

    // Reset with active-looking inputs, then read x_cur + acc through a capture.
    do_cycle(0, 0, 1, 0, 0, 1, 100, 0);
    do_cycle(0, 0, 1, 0, 0, 1, 100, 0);
    check_value("reset_y_out", int'(y_out), 0);
    do_cycle(0, 2, 3, 0, 1, 0, 0, 1);
    check_value("reset_xcur_acc", int'(y_out), 0);
    idle();

    // Nominal sequence, then expose fk and x_prev via later captures.
    nominal(0);
    check_value("nominal_y", int'(y_out), -96);
    idle();
    do_cycle(0, 1, 0, 0, 1, 0, 0, 1);
    check_value("nominal_fk_plus_acc", int'(y_out), 160);
    idle();
    do_cycle(0, 3, 3, 0, 1, 0, 0, 1);
    check_value("nominal_xprev", int'(y_out), 256);
    idle();

    // Saturation in both directions.
    for (int k = 0; k < 2; k++) begin
      int v;
      v = (k == 0) ? 32767 : -32768;
      do_cycle(0, 0, 0, 0, 0, 1, v, 1);
      for (int j = 0; j < 3; j++) do_cycle(0, 2, 1, 0, 0, 0, 0, 1);
      do_cycle(0, 2, 1, 0, 1, 0, 0, 1);
      check_value("sat_y", int'(y_out), v);
      check_value("sat_ovf", int'(y_ovf), 1);
      idle();
    end

    // Listo held three cycles: one pulse, acc keeps summing; sel_const 6 acts as C0.
    do_cycle(0, 0, 0, 0, 0, 1, 100, 1);
    do_cycle(6, 2, 1, 0, 1, 0, 0, 1);
    check_value("held_first_y", int'(y_out), 100);
    do_cycle(0, 2, 1, 0, 1, 0, 0, 1);
    do_cycle(0, 2, 1, 0, 1, 0, 0, 1);
    check_value("held_y_hold", int'(y_out), 100);
    idle();
    do_cycle(0, 0, 3, 0, 1, 0, 0, 1);
    check_value("held_acc", int'(y_out), 300);
    idle();

    // Simultaneous load and shift.
    do_cycle(0, 0, 0, 0, 0, 1, 300, 1);
    do_cycle(0, 0, 3, 1, 0, 1, 500, 1);
    do_cycle(0, 3, 3, 0, 1, 0, 0, 1);
    check_value("shift_xprev", int'(y_out), 300);
    idle();
    do_cycle(0, 2, 3, 0, 1, 0, 0, 1);
    check_value("shift_xcur", int'(y_out), 500);
    idle();

    // Reset in the Listo cycle suppresses the pulse and clears acc/fk.
    nominal(1);
    check_value("midreset_valid", int'(y_valid), 0);
    check_value("midreset_y", int'(y_out), 0);
    do_cycle(0, 1, 3, 0, 1, 0, 0, 1);
    check_value("midreset_acc_fk", int'(y_out), 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
